// File: rtl/stats_pkg.sv
// Shared types and constants for the run-statistics sequencer.
package stats_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_SNAP,
    ST_DUMP,
    ST_DONE
  } state_t;

  localparam int NUM_FIELDS = 4;

  typedef logic [1:0] fld_t;

  localparam fld_t FLD_CYC = 2'd0;
  localparam fld_t FLD_INS = 2'd1;
  localparam fld_t FLD_STL = 2'd2;
  localparam fld_t FLD_FLG = 2'd3;

  localparam fld_t FLD_LAST = fld_t'(NUM_FIELDS - 1);

endpackage

// File: rtl/stats_controller_stat_counter.sv
// Saturating event counter with a sticky overflow flag.
// The flag sets on any increment attempted while the counter is already at max.
module stat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (count == CNT_MAX) begin
        ovf <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stats_controller.sv
// Run-statistics sequencer: counts cycles, retires and stalls during a run,
// then streams a frozen snapshot of four report fields over valid/ready.
//
// state | meaning
// IDLE  | waiting for run_start; last snapshot still readable
// COUNT | run active, counters advancing every cycle
// SNAP  | one cycle: copy counters into snapshot registers
// DUMP  | stream fields 0..3 to the reporting unit
// DONE  | one-cycle done pulse, then back to IDLE
module stats_controller
  import stats_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_start,
  input  logic             run_end,
  input  logic             instr_retire,
  input  logic             stall,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [1:0]       rd_id,
  output logic [CNT_W-1:0] rd_data,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_clr;
  logic             w_cnt_en;
  logic             w_accept;

  logic [CNT_W-1:0] w_cyc_cnt;
  logic [CNT_W-1:0] w_ins_cnt;
  logic [CNT_W-1:0] w_stl_cnt;
  logic             w_cyc_ovf;
  logic             w_ins_ovf;
  logic             w_stl_ovf;

  logic [CNT_W-1:0] r_snap_cyc;
  logic [CNT_W-1:0] r_snap_ins;
  logic [CNT_W-1:0] r_snap_stl;
  logic [2:0]       r_snap_flg;
  fld_t             r_idx;
  logic             r_busy;
  logic             r_done;

  stat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .inc   (w_cnt_en),
    .count (w_cyc_cnt),
    .ovf   (w_cyc_ovf)
  );

  stat_counter #(.CNT_W(CNT_W)) u_ins_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .inc   (w_cnt_en & instr_retire),
    .count (w_ins_cnt),
    .ovf   (w_ins_ovf)
  );

  stat_counter #(.CNT_W(CNT_W)) u_stl_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .inc   (w_cnt_en & stall),
    .count (w_stl_cnt),
    .ovf   (w_stl_ovf)
  );

  assign w_accept = (r_state == ST_DUMP) && rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run_start) begin
          w_state_nxt = ST_COUNT;
          w_clr       = 1'b1;
        end
      end
      ST_COUNT: begin
        // The edge that samples run_end still counts, so N edges give cycles=N.
        w_cnt_en = 1'b1;
        if (run_end) begin
          w_state_nxt = ST_SNAP;
        end
      end
      ST_SNAP: begin
        w_state_nxt = ST_DUMP;
      end
      ST_DUMP: begin
        if (w_accept && (r_idx == FLD_LAST)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_cyc <= '0;
      r_snap_ins <= '0;
      r_snap_stl <= '0;
      r_snap_flg <= '0;
    end else if (r_state == ST_SNAP) begin
      r_snap_cyc <= w_cyc_cnt;
      r_snap_ins <= w_ins_cnt;
      r_snap_stl <= w_stl_cnt;
      r_snap_flg <= {w_stl_ovf, w_ins_ovf, w_cyc_ovf};
    end
  end

  // Index parks on the last field after the dump so rd_id keeps its final value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= FLD_CYC;
    end else if (r_state == ST_SNAP) begin
      r_idx <= FLD_CYC;
    end else if (w_accept && (r_idx != FLD_LAST)) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_COUNT) || (w_state_nxt == ST_SNAP) ||
                (w_state_nxt == ST_DUMP);
      r_done <= (w_state_nxt == ST_DONE);
    end
  end

  always_comb begin
    rd_data = '0;
    case (r_idx)
      FLD_CYC: rd_data = r_snap_cyc;
      FLD_INS: rd_data = r_snap_ins;
      FLD_STL: rd_data = r_snap_stl;
      FLD_FLG: rd_data = {{(CNT_W-3){1'b0}}, r_snap_flg};
      default: rd_data = '0;
    endcase
  end

  assign rd_valid = (r_state == ST_DUMP);
  assign rd_id    = r_idx;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
